// File: rtl/diff_core_pkg.sv
// Shared constants and types for the diff core datapath: psum widths,
// accumulation buffer depth, activation clamp limits and accumulator FSM states.
package diff_core_pkg;

  localparam int PSUM_WIDTH                  = 32;
  localparam int FM_GUARD_GEN_PSUM_BUF_DEPTH = 512;

  localparam int unsigned ACT_MAX_8 = 255;
  localparam int unsigned ACT_MAX_4 = 15;

  typedef enum logic [1:0] {
    ACC_IDLE,
    ACC_ACCUM,
    ACC_DRAIN
  } psum_acc_state_t;

endpackage

// File: rtl/psum_requant.sv
// Combinational requantisation of one psum: ReLU, right shift, then clamp to
// the 8-bit or 4-bit activation range selected by bit_mode.
module psum_requant #(
  parameter int PSUM_WIDTH = diff_core_pkg::PSUM_WIDTH
) (
  input  logic [PSUM_WIDTH-1:0] psum,
  input  logic [4:0]            shift,
  input  logic                  bit_mode,
  output logic [7:0]            act
);
  import diff_core_pkg::*;

  logic [PSUM_WIDTH-1:0] relu;
  logic [PSUM_WIDTH-1:0] shifted;
  logic [PSUM_WIDTH-1:0] lim;

  // After ReLU the value is non-negative, so a logical shift equals >>>.
  always_comb begin
    relu    = psum[PSUM_WIDTH-1] ? '0 : psum;
    shifted = relu >> shift;
    lim     = bit_mode ? PSUM_WIDTH'(ACT_MAX_4) : PSUM_WIDTH'(ACT_MAX_8);
    act     = (shifted > lim) ? lim[7:0] : shifted[7:0];
  end

endmodule

// File: rtl/psum_accum_buf.sv
// Per-row partial-sum accumulation buffer: accumulates psums over several
// passes, then drains entries through psum_requant. Macro PSUM_ACC_SAT_EN
// selects saturating accumulation and adds the sticky ovf output.
module psum_accum_buf #(
  parameter int PSUM_WIDTH = diff_core_pkg::PSUM_WIDTH,
  parameter int DEPTH      = diff_core_pkg::FM_GUARD_GEN_PSUM_BUF_DEPTH,
  parameter int ADDR_W     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [ADDR_W:0]       cfg_len,
  input  logic [7:0]            cfg_passes,
  input  logic [4:0]            cfg_shift,
  input  logic                  cfg_bit_mode,
  input  logic                  psum_valid,
  output logic                  psum_ready,
  input  logic [PSUM_WIDTH-1:0] psum_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [7:0]            out_data,
  output logic                  done
`ifdef PSUM_ACC_SAT_EN
  ,
  output logic                  ovf
`endif
);
  import diff_core_pkg::*;

  psum_acc_state_t state, state_nxt;

  logic [ADDR_W:0]       len_q, rd_ptr, cfg_len_m1;
  logic [ADDR_W-1:0]     len_m1, wr_ptr;
  logic [7:0]            passes_m1, pass_cnt;
  logic [4:0]            shift_q;
  logic                  mode_q;
  logic [PSUM_WIDTH-1:0] mem [DEPTH];

  logic                  cfg_fire, cfg_degen, psum_fire, last_psum;
  logic                  drain_load, drain_end;
  logic [PSUM_WIDTH-1:0] acc_old, acc_new;
  logic                  acc_clamp;
  logic [7:0]            act;

  assign cfg_ready  = (state == ACC_IDLE);
  assign psum_ready = (state == ACC_ACCUM);
  assign cfg_len_m1 = cfg_len - (ADDR_W+1)'(1);
  assign acc_old    = mem[wr_ptr];

  always_comb begin
    acc_clamp = 1'b0;
`ifdef PSUM_ACC_SAT_EN
    begin
      logic [PSUM_WIDTH:0] sum_ext;
      sum_ext = {acc_old[PSUM_WIDTH-1], acc_old} + {psum_data[PSUM_WIDTH-1], psum_data};
      if (sum_ext[PSUM_WIDTH] != sum_ext[PSUM_WIDTH-1]) begin
        acc_clamp = 1'b1;
        acc_new   = sum_ext[PSUM_WIDTH] ? {1'b1, {(PSUM_WIDTH-1){1'b0}}}
                                        : {1'b0, {(PSUM_WIDTH-1){1'b1}}};
      end else begin
        acc_new = sum_ext[PSUM_WIDTH-1:0];
      end
    end
`else
    acc_new = acc_old + psum_data;
`endif
    if (pass_cnt == 8'd0) begin
      acc_new   = psum_data;
      acc_clamp = 1'b0;
    end
  end

  always_comb begin
    state_nxt  = state;
    cfg_fire   = 1'b0;
    cfg_degen  = 1'b0;
    psum_fire  = 1'b0;
    last_psum  = 1'b0;
    drain_load = 1'b0;
    drain_end  = 1'b0;
    case (state)
      ACC_IDLE: begin
        if (cfg_valid) begin
          if (cfg_len == '0 || cfg_passes == 8'd0) begin
            cfg_degen = 1'b1;
          end else begin
            cfg_fire  = 1'b1;
            state_nxt = ACC_ACCUM;
          end
        end
      end
      ACC_ACCUM: begin
        psum_fire = psum_valid;
        last_psum = psum_valid && (wr_ptr == len_m1) && (pass_cnt == passes_m1);
        if (last_psum) state_nxt = ACC_DRAIN;
      end
      ACC_DRAIN: begin
        // rd_ptr points one past the entry currently presented on out_data.
        if (!out_valid) begin
          drain_load = 1'b1;
        end else if (out_ready) begin
          if (rd_ptr == len_q) begin
            drain_end = 1'b1;
            state_nxt = ACC_IDLE;
          end else begin
            drain_load = 1'b1;
          end
        end
      end
      default: state_nxt = ACC_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ACC_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      len_q     <= '0;
      len_m1    <= '0;
      passes_m1 <= '0;
      shift_q   <= '0;
      mode_q    <= 1'b0;
      wr_ptr    <= '0;
      pass_cnt  <= '0;
      rd_ptr    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      done      <= 1'b0;
`ifdef PSUM_ACC_SAT_EN
      ovf       <= 1'b0;
`endif
    end else begin
      done <= cfg_degen || drain_end;
      if (cfg_fire) begin
        len_q     <= cfg_len;
        len_m1    <= cfg_len_m1[ADDR_W-1:0];
        passes_m1 <= cfg_passes - 8'd1;
        shift_q   <= cfg_shift;
        mode_q    <= cfg_bit_mode;
        wr_ptr    <= '0;
        pass_cnt  <= '0;
        rd_ptr    <= '0;
      end
`ifdef PSUM_ACC_SAT_EN
      if (cfg_fire || cfg_degen) ovf <= 1'b0;
      else if (psum_fire && acc_clamp) ovf <= 1'b1;
`endif
      if (psum_fire) begin
        if (wr_ptr == len_m1) begin
          wr_ptr   <= '0;
          pass_cnt <= pass_cnt + 8'd1;
        end else begin
          wr_ptr <= wr_ptr + ADDR_W'(1);
        end
      end
      if (drain_load) begin
        out_valid <= 1'b1;
        out_data  <= act;
        rd_ptr    <= rd_ptr + (ADDR_W+1)'(1);
      end
      if (drain_end) out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (psum_fire) mem[wr_ptr] <= acc_new;
  end

  psum_requant #(
    .PSUM_WIDTH(PSUM_WIDTH)
  ) u_requant (
    .psum    (mem[rd_ptr[ADDR_W-1:0]]),
    .shift   (shift_q),
    .bit_mode(mode_q),
    .act     (act)
  );

endmodule
